// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction fetch unit.
//   fetch_state_t    - fetch FSM state encoding
//   FETCH_ALIGN_MASK - PC bits that must be zero for an aligned fetch
//   FETCH_COUNT_W    - width of the accepted-instruction counter
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4,
    ST_FAULT = 3'd5
  } fetch_state_t;

  localparam logic [1:0] FETCH_ALIGN_MASK = 2'b11;

  localparam int unsigned FETCH_COUNT_W = 32;

endpackage

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches one instruction per PC from instruction memory
// and hands it, tagged with its PC, to decode.
//   clk, reset           - clock, asynchronous active-low reset
//   pc_value / pc_en     - PC from the PC controller / advance pulse back to it
//   imem_req_*, imem_addr - read request channel (valid/ready)
//   imem_rsp_*           - read response (no back-pressure)
//   flush                - discard the current fetch
//   instr_*              - instruction + PC to decode (valid/ready)
//   fault                - sticky misaligned-PC flag, cleared only by reset
//   fetch_count          - instructions accepted by decode, wraps
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DWIDTH-1:0]        pc_value,
  output logic                     pc_en,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [DWIDTH-1:0]        imem_addr,
  input  logic                     imem_rsp_valid,
  input  logic [DWIDTH-1:0]        imem_rsp_data,
  input  logic                     flush,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DWIDTH-1:0]        instr_out,
  output logic [DWIDTH-1:0]        instr_pc,
  output logic                     fault,
  output logic [FETCH_COUNT_W-1:0] fetch_count
);

  fetch_state_t state, state_nxt;
  logic         misaligned;
  logic         cap_pc;
  logic         cap_instr;
  logic         set_fault;

  assign misaligned = |(pc_value[1:0] & FETCH_ALIGN_MASK);

  // Flush outranks every same-cycle event except the alignment check in REQ.
  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    imem_addr      = '0;
    instr_valid    = 1'b0;
    pc_en          = 1'b0;
    cap_pc         = 1'b0;
    cap_instr      = 1'b0;
    set_fault      = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ: begin
        imem_addr = pc_value;
        if (misaligned) begin
          set_fault = 1'b1;
          state_nxt = ST_FAULT;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) begin
            cap_pc    = 1'b1;
            // the request is already out, so its response must still be drained
            state_nxt = flush ? ST_DRAIN : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (flush) begin
            state_nxt = ST_REQ;
          end else begin
            cap_instr = 1'b1;
            state_nxt = ST_HOLD;
          end
        end else if (flush) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (imem_rsp_valid) state_nxt = ST_REQ;
      end
      ST_HOLD: begin
        instr_valid = 1'b1;
        if (flush) begin
          state_nxt = ST_REQ;
        end else if (instr_ready) begin
          pc_en     = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      instr_out   <= '0;
      instr_pc    <= '0;
      fault       <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_nxt;
      if (cap_pc)    instr_pc  <= pc_value;
      if (cap_instr) instr_out <= imem_rsp_data;
      if (set_fault) fault     <= 1'b1;
      if (pc_en)     fetch_count <= fetch_count + FETCH_COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_value = '0;
  logic        pc_en;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        flush = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        fault;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DWIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_value       (pc_value),
    .pc_en          (pc_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .flush          (flush),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  typedef struct {
    logic        rst_n;
    logic [31:0] pc;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        fl;
    logic        ir;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic        e_pce;
    logic [31:0] e_io;
    logic [31:0] e_ip;
    logic        e_flt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst_n, input logic [31:0] pc, input logic rdy,
                     input logic rv, input logic [31:0] rd, input logic fl,
                     input logic ir, input logic e_rqv, input logic [31:0] e_addr,
                     input logic e_iv, input logic e_pce, input logic [31:0] e_io,
                     input logic [31:0] e_ip, input logic e_flt, input logic [31:0] e_cnt);
    vec_t v;
    v.rst_n = rst_n; v.pc = pc; v.rdy = rdy; v.rv = rv; v.rd = rd; v.fl = fl; v.ir = ir;
    v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pce = e_pce;
    v.e_io = e_io; v.e_ip = e_ip; v.e_flt = e_flt; v.e_cnt = e_cnt;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d got %h want %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int          pulses;
    int          last_pulse;
    logic        hs_prev;
    logic [31:0] last_addr;
    logic [31:0] pc_m;

    //   rst pc        rdy rv rd            fl ir | rqv addr  iv pce io           ip     flt cnt
    add(0, 32'h00,     0, 0, 32'h0,        0, 0,  0, 32'h00, 0, 0, 32'h0,        32'h00, 0, 0);
    add(0, 32'h00,     0, 0, 32'h0,        0, 0,  0, 32'h00, 0, 0, 32'h0,        32'h00, 0, 0);
    add(1, 32'h00,     0, 0, 32'h0,        0, 1,  0, 32'h00, 0, 0, 32'h0,        32'h00, 0, 0);
    // zero-wait fetch at 0x00
    add(1, 32'h00,     1, 0, 32'h0,        0, 1,  1, 32'h00, 0, 0, 32'h0,        32'h00, 0, 0);
    add(1, 32'h00,     1, 1, 32'h13,       0, 1,  0, 32'h00, 0, 0, 32'h0,        32'h00, 0, 0);
    add(1, 32'h00,     1, 0, 32'h0,        0, 1,  0, 32'h00, 1, 1, 32'h13,       32'h00, 0, 0);
    // request stalled 4 cycles at 0x10 (stray response in REQ ignored)
    add(1, 32'h10,     0, 1, 32'hFFFFFFFF, 0, 1,  1, 32'h10, 0, 0, 32'h13,       32'h00, 0, 1);
    add(1, 32'h10,     0, 0, 32'h0,        0, 1,  1, 32'h10, 0, 0, 32'h13,       32'h00, 0, 1);
    add(1, 32'h10,     0, 0, 32'h0,        0, 1,  1, 32'h10, 0, 0, 32'h13,       32'h00, 0, 1);
    add(1, 32'h10,     0, 0, 32'h0,        0, 1,  1, 32'h10, 0, 0, 32'h13,       32'h00, 0, 1);
    add(1, 32'h10,     1, 0, 32'h0,        0, 1,  1, 32'h10, 0, 0, 32'h13,       32'h00, 0, 1);
    add(1, 32'h10,     0, 0, 32'h0,        0, 0,  0, 32'h00, 0, 0, 32'h13,       32'h10, 0, 1);
    add(1, 32'h10,     0, 1, 32'h00500093, 0, 0,  0, 32'h00, 0, 0, 32'h13,       32'h10, 0, 1);
    // decode stalls 5 cycles in HOLD (stray response ignored)
    add(1, 32'h10,     0, 1, 32'hFFFFFFFF, 0, 0,  0, 32'h00, 1, 0, 32'h00500093, 32'h10, 0, 1);
    add(1, 32'h10,     0, 0, 32'h0,        0, 0,  0, 32'h00, 1, 0, 32'h00500093, 32'h10, 0, 1);
    add(1, 32'h10,     0, 0, 32'h0,        0, 0,  0, 32'h00, 1, 0, 32'h00500093, 32'h10, 0, 1);
    add(1, 32'h10,     0, 0, 32'h0,        0, 0,  0, 32'h00, 1, 0, 32'h00500093, 32'h10, 0, 1);
    add(1, 32'h10,     0, 0, 32'h0,        0, 0,  0, 32'h00, 1, 0, 32'h00500093, 32'h10, 0, 1);
    add(1, 32'h10,     0, 0, 32'h0,        0, 1,  0, 32'h00, 1, 1, 32'h00500093, 32'h10, 0, 1);
    // flush in WAIT, DEADBEEF drained, redirect to 0x40
    add(1, 32'h14,     1, 0, 32'h0,        0, 0,  1, 32'h14, 0, 0, 32'h00500093, 32'h10, 0, 2);
    add(1, 32'h14,     0, 0, 32'h0,        1, 0,  0, 32'h00, 0, 0, 32'h00500093, 32'h14, 0, 2);
    add(1, 32'h40,     0, 0, 32'h0,        0, 0,  0, 32'h00, 0, 0, 32'h00500093, 32'h14, 0, 2);
    add(1, 32'h40,     0, 1, 32'hDEADBEEF, 0, 0,  0, 32'h00, 0, 0, 32'h00500093, 32'h14, 0, 2);
    add(1, 32'h40,     1, 0, 32'h0,        0, 0,  1, 32'h40, 0, 0, 32'h00500093, 32'h14, 0, 2);
    add(1, 32'h40,     0, 1, 32'h00108093, 0, 0,  0, 32'h00, 0, 0, 32'h00500093, 32'h40, 0, 2);
    // flush together with instr_ready in HOLD
    add(1, 32'h40,     0, 0, 32'h0,        1, 1,  0, 32'h00, 1, 0, 32'h00108093, 32'h40, 0, 2);
    // flush in REQ without, then with, a handshake
    add(1, 32'h40,     0, 0, 32'h0,        1, 0,  1, 32'h40, 0, 0, 32'h00108093, 32'h40, 0, 2);
    add(1, 32'h40,     1, 0, 32'h0,        1, 0,  1, 32'h40, 0, 0, 32'h00108093, 32'h40, 0, 2);
    add(1, 32'h44,     0, 1, 32'h11111111, 0, 0,  0, 32'h00, 0, 0, 32'h00108093, 32'h40, 0, 2);
    // flush in WAIT with the response in the same cycle
    add(1, 32'h44,     1, 0, 32'h0,        0, 0,  1, 32'h44, 0, 0, 32'h00108093, 32'h40, 0, 2);
    add(1, 32'h44,     0, 1, 32'h22222222, 1, 0,  0, 32'h00, 0, 0, 32'h00108093, 32'h44, 0, 2);
    // misaligned PC traps; fault sticky across flush
    add(1, 32'h06,     1, 0, 32'h0,        0, 0,  0, 32'h06, 0, 0, 32'h00108093, 32'h44, 0, 2);
    add(1, 32'h06,     1, 1, 32'h55,       1, 1,  0, 32'h00, 0, 0, 32'h00108093, 32'h44, 1, 2);
    add(1, 32'h06,     1, 0, 32'h0,        0, 0,  0, 32'h00, 0, 0, 32'h00108093, 32'h44, 1, 2);
    // reset clears everything
    add(0, 32'h00,     0, 0, 32'h0,        0, 0,  0, 32'h00, 0, 0, 32'h0,        32'h00, 0, 0);
    add(1, 32'h00,     0, 0, 32'h0,        0, 0,  0, 32'h00, 0, 0, 32'h0,        32'h00, 0, 0);
    add(1, 32'h00,     1, 0, 32'h0,        0, 1,  1, 32'h00, 0, 0, 32'h0,        32'h00, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset          = vq[i].rst_n;
      pc_value       = vq[i].pc;
      imem_req_ready = vq[i].rdy;
      imem_rsp_valid = vq[i].rv;
      imem_rsp_data  = vq[i].rd;
      flush          = vq[i].fl;
      instr_ready    = vq[i].ir;
      #1;
      chk("req_valid",   i, 32'(imem_req_valid), 32'(vq[i].e_rqv));
      chk("imem_addr",   i, imem_addr,           vq[i].e_addr);
      chk("instr_valid", i, 32'(instr_valid),    32'(vq[i].e_iv));
      chk("pc_en",       i, 32'(pc_en),          32'(vq[i].e_pce));
      chk("instr_out",   i, instr_out,           vq[i].e_io);
      chk("instr_pc",    i, instr_pc,            vq[i].e_ip);
      chk("fault",       i, 32'(fault),          32'(vq[i].e_flt));
      chk("fetch_count", i, fetch_count,         vq[i].e_cnt);
    end

    // Zero-wait streaming: last table row handshook PC 0, so DUT is in WAIT.
    pulses     = 0;
    last_pulse = -1;
    hs_prev    = 1'b1;
    last_addr  = 32'h0;
    pc_m       = 32'h0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      reset          = 1'b1;
      flush          = 1'b0;
      imem_req_ready = 1'b1;
      instr_ready    = 1'b1;
      pc_value       = pc_m;
      imem_rsp_valid = hs_prev;
      imem_rsp_data  = last_addr + 32'h1000_0000;
      #1;
      if (pc_en) begin
        pulses++;
        if (last_pulse >= 0) chk("period", c, 32'(c - last_pulse), 32'd3);
        chk("stream_pc",    c, instr_pc,  pc_m);
        chk("stream_instr", c, instr_out, pc_m + 32'h1000_0000);
        last_pulse = c;
      end
      hs_prev = imem_req_valid & imem_req_ready;
      if (hs_prev) last_addr = imem_addr;
      if (pc_en) pc_m = pc_m + 32'd4;
    end
    chk("stream_pulses", 0, 32'(pulses), 32'd4);
    chk("stream_count",  0, fetch_count, 32'd4);

    // Asynchronous reset while a request is outstanding; stale response ignored.
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_req_valid", 0, 32'(imem_req_valid), 32'd0);
    chk("arst_addr",      0, imem_addr,           32'd0);
    chk("arst_instr_out", 0, instr_out,           32'd0);
    chk("arst_instr_pc",  0, instr_pc,            32'd0);
    chk("arst_count",     0, fetch_count,         32'd0);
    chk("arst_fault",     0, 32'(fault),          32'd0);
    @(negedge clk);
    reset          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h33333333;
    #1;
    chk("idle_req_valid", 0, 32'(imem_req_valid), 32'd0);
    chk("idle_instr_out", 0, instr_out,           32'd0);
    @(negedge clk);
    pc_value = 32'h80;
    #1;
    chk("post_req_valid", 0, 32'(imem_req_valid), 32'd1);
    chk("post_addr",      0, imem_addr,           32'h80);
    chk("post_instr_out", 0, instr_out,           32'd0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h44;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    #1;
    chk("post_instr_valid", 0, 32'(instr_valid), 32'd1);
    chk("post_instr",       0, instr_out,        32'h44);
    chk("post_instr_pc",    0, instr_pc,         32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
